// File: rtl/timer_pkg.sv
// Shared constants for the timer LED demo: default clock/strobe frequencies,
// debounce FSM encodings and a counter-width helper.
package timer_pkg;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_PLS_FREQ = 1000;

  // Debounce FSM encodings; level 0 lives in IDLE/WAIT_HI, level 1 in HIGH/WAIT_LO.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_HI = 2'd1;
  localparam logic [1:0] HIGH    = 2'd2;
  localparam logic [1:0] WAIT_LO = 2'd3;

  typedef logic [1:0] db_state_t;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n < 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer followed by either the debounce
// FSM (TICK_GEN_DEBOUNCE_EN defined) or a plain registered edge detector.
module btn_debounce
  import timer_pkg::*;
#(
  parameter int DB_MS = 20
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_btn_lvl,
  output logic o_go
);

  logic meta_q;
  logic s_btn_q;
  logic lvl_q;
  logic lvl_d;
  logic go_q;
  logic go_d;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      meta_q  <= 1'b0;
      s_btn_q <= 1'b0;
    end else begin
      meta_q  <= i_btn;
      s_btn_q <= meta_q;
    end
  end

`ifdef TICK_GEN_DEBOUNCE_EN

  localparam int              DB_W    = cnt_width(DB_MS + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_MS - 1);

  db_state_t        state_q;
  db_state_t        state_d;
  logic [DB_W-1:0]  db_q;
  logic [DB_W-1:0]  db_d;

  // Any sample disagreeing with the pending level drops back and restarts the count.
  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    lvl_d   = lvl_q;
    go_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_btn_q) begin
          state_d = WAIT_HI;
          db_d    = '0;
        end
      end
      WAIT_HI: begin
        if (!s_btn_q) begin
          state_d = IDLE;
        end else if (i_tick) begin
          if (db_q == DB_LAST) begin
            state_d = HIGH;
            lvl_d   = 1'b1;
            go_d    = 1'b1;
          end else begin
            db_d = db_q + 1'b1;
          end
        end
      end
      HIGH: begin
        if (!s_btn_q) begin
          state_d = WAIT_LO;
          db_d    = '0;
        end
      end
      WAIT_LO: begin
        if (s_btn_q) begin
          state_d = HIGH;
        end else if (i_tick) begin
          if (db_q == DB_LAST) begin
            state_d = IDLE;
            lvl_d   = 1'b0;
          end else begin
            db_d = db_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        db_d    = '0;
        lvl_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      db_q    <= '0;
      lvl_q   <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      lvl_q   <= lvl_d;
      go_q    <= go_d;
    end
  end

`else

  // Tick and debounce length have no role without the FSM.
  logic        unused_tick;
  logic [31:0] unused_db_ms;
  assign unused_tick  = i_tick;
  assign unused_db_ms = DB_MS;

  // lvl_q doubles as the previous synchronized sample for the edge detector.
  always_comb begin
    lvl_d = s_btn_q;
    go_d  = s_btn_q & ~lvl_q;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      lvl_q <= 1'b0;
      go_q  <= 1'b0;
    end else begin
      lvl_q <= lvl_d;
      go_q  <= go_d;
    end
  end

`endif

  assign o_btn_lvl = lvl_q;
  assign o_go      = go_q;

endmodule

// File: rtl/tick_gen.sv
// Clock divider producing the fast strobe and the slow strobe, plus the start
// button conditioner. Define TICK_GEN_DEBOUNCE_EN to build the debounce FSM.
module tick_gen
  import timer_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int PLS_FREQ = DEF_PLS_FREQ,
  parameter int SLOW_DIV = 1000,
  parameter int DB_MS    = 20
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clr,
  input  logic i_btn,
  output logic o_pls_1k,
  output logic o_pls_1hz,
  output logic o_btn_lvl,
  output logic o_go
);

  localparam int                DIV       = CLK_FREQ / PLS_FREQ;
  localparam int                DIV_W     = cnt_width(DIV);
  localparam int                SLOW_W    = cnt_width(SLOW_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_DIV - 1);

  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_d;
  logic [SLOW_W-1:0] slow_q;
  logic [SLOW_W-1:0] slow_d;
  logic              pls_1k_q;
  logic              pls_1k_d;
  logic              pls_1hz_q;
  logic              pls_1hz_d;
  logic              tick;

  // A wrap coinciding with a clear is swallowed: clear re-phases everything downstream.
  always_comb begin
    tick      = (div_q == DIV_LAST) && !i_clr;
    div_d     = div_q;
    slow_d    = slow_q;
    pls_1k_d  = tick;
    pls_1hz_d = tick && (slow_q == SLOW_LAST);
    if (i_clr) begin
      div_d  = '0;
      slow_d = '0;
    end else begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
      end else begin
        div_d = div_q + 1'b1;
      end
      if (tick) begin
        if (slow_q == SLOW_LAST) begin
          slow_d = '0;
        end else begin
          slow_d = slow_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      div_q     <= '0;
      slow_q    <= '0;
      pls_1k_q  <= 1'b0;
      pls_1hz_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      slow_q    <= slow_d;
      pls_1k_q  <= pls_1k_d;
      pls_1hz_q <= pls_1hz_d;
    end
  end

  btn_debounce #(
    .DB_MS (DB_MS)
  ) u_btn_debounce (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_tick    (tick),
    .i_btn     (i_btn),
    .o_btn_lvl (o_btn_lvl),
    .o_go      (o_go)
  );

  assign o_pls_1k  = pls_1k_q;
  assign o_pls_1hz = pls_1hz_q;

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen: directed scenarios plus random button/clear traffic, all
// outputs compared every cycle against an edge-count reference model.
module tb_tick_gen;

  localparam int CLK_FREQ = 10_000;
  localparam int PLS_FREQ = 1000;
  localparam int DIV      = CLK_FREQ / PLS_FREQ;
  localparam int SLOW_DIV = 4;
  localparam int DB_MS    = 3;

  logic i_clk = 1'b0;
  logic i_rstn;
  logic i_clr;
  logic i_btn;
  logic o_pls_1k;
  logic o_pls_1hz;
  logic o_btn_lvl;
  logic o_go;

  int n_checks = 0;
  int n_fail   = 0;

  tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .PLS_FREQ (PLS_FREQ),
    .SLOW_DIV (SLOW_DIV),
    .DB_MS    (DB_MS)
  ) dut (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_clr     (i_clr),
    .i_btn     (i_btn),
    .o_pls_1k  (o_pls_1k),
    .o_pls_1hz (o_pls_1hz),
    .o_btn_lvl (o_btn_lvl),
    .o_go      (o_go)
  );

  // ---------------- clock ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // n_edge: clock edges since reset release; n_phase: edges since release or last clear.
  int n_edge      = 0;
  int n_phase     = 0;
  int run_start   = -1;
  int m_ticks     = 0;
  bit btn_hist[$];
  bit tick_hist[$];
  bit exp_1k      = 1'b0;
  bit exp_1hz     = 1'b0;
  bit exp_lvl     = 1'b0;
  bit exp_go      = 1'b0;
  bit s_now;

  // Button value the conditioner acts on at edge idx (two edges of synchronizer delay).
  function automatic bit hist_at(input int idx);
    if (idx < 0) return 1'b0;
    return btn_hist[idx];
  endfunction

  always @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      n_edge    = 0;
      n_phase   = 0;
      run_start = -1;
      btn_hist.delete();
      tick_hist.delete();
      exp_1k    = 1'b0;
      exp_1hz   = 1'b0;
      exp_lvl   = 1'b0;
      exp_go    = 1'b0;
    end else begin
      btn_hist.push_back(i_btn);
      if (i_clr) n_phase = 0;
      else       n_phase = n_phase + 1;
      exp_1k  = !i_clr && (n_phase % DIV == 0);
      exp_1hz = exp_1k && (n_phase % (DIV * SLOW_DIV) == 0);
      tick_hist.push_back(exp_1k);
      s_now = hist_at(n_edge - 2);
`ifdef TICK_GEN_DEBOUNCE_EN
      // Level follows the button once DB_MS ticks pass with the button continuously
      // differing from it; ticks on the edge the difference is first seen do not count.
      exp_go = 1'b0;
      if (s_now == exp_lvl) begin
        run_start = -1;
      end else if (run_start < 0) begin
        run_start = n_edge;
      end else begin
        m_ticks = 0;
        for (int i = run_start + 1; i <= n_edge; i++) m_ticks += int'(tick_hist[i]);
        if (m_ticks >= DB_MS) begin
          exp_lvl   = s_now;
          exp_go    = s_now;
          run_start = -1;
        end
      end
`else
      exp_lvl = s_now;
      exp_go  = s_now && !hist_at(n_edge - 3);
`endif
      n_edge = n_edge + 1;
    end
  end

  // ---------------- per-cycle scoreboard ----------------
  int cnt_1k, cnt_1hz, cnt_go;
  int first_1k, first_1hz, first_go;

  always @(negedge i_clk) begin
    check_eq("pls_1k",  32'(o_pls_1k),  32'(exp_1k));
    check_eq("pls_1hz", 32'(o_pls_1hz), 32'(exp_1hz));
    check_eq("btn_lvl", 32'(o_btn_lvl), 32'(exp_lvl));
    check_eq("go",      32'(o_go),      32'(exp_go));
    if (o_pls_1k === 1'b1) begin
      cnt_1k++;
      if (first_1k < 0) first_1k = n_edge;
    end
    if (o_pls_1hz === 1'b1) begin
      cnt_1hz++;
      if (first_1hz < 0) first_1hz = n_edge;
    end
    if (o_go === 1'b1) begin
      cnt_go++;
      if (first_go < 0) first_go = n_edge;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  task automatic clear_counts();
    cnt_1k    = 0;
    cnt_1hz   = 0;
    cnt_go    = 0;
    first_1k  = -1;
    first_1hz = -1;
    first_go  = -1;
  endtask

  task automatic do_reset();
    i_rstn = 1'b0;
    i_clr  = 1'b0;
    step();
    step();
    i_rstn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int settle_cyc;
  int rel_cyc;
  int lvl_fall;
  int ticks_seen;
  int seg_left;

  initial begin
    i_rstn = 1'b0;
    i_clr  = 1'b0;
    i_btn  = 1'b0;
    clear_counts();
    repeat (3) step();
    check_eq("rst_pls_1k",  32'(o_pls_1k),  32'd0);
    check_eq("rst_pls_1hz", 32'(o_pls_1hz), 32'd0);
    check_eq("rst_btn_lvl", 32'(o_btn_lvl), 32'd0);
    check_eq("rst_go",      32'(o_go),      32'd0);

    // Free-running strobes for 100 clocks.
    i_rstn = 1'b1;
    clear_counts();
    repeat (100) step();
    check_eq("cnt_1k_100",   32'(cnt_1k),    32'd10);
    check_eq("cnt_1hz_100",  32'(cnt_1hz),   32'd2);
    check_eq("first_1k",     32'(first_1k),  32'(DIV));
    check_eq("first_1hz",    32'(first_1hz), 32'(DIV * SLOW_DIV));

    // Clear pulsed at cycle 15 re-phases both counters.
    do_reset();
    repeat (15) step();
    i_clr = 1'b1;
    clear_counts();
    step();
    i_clr = 1'b0;
    repeat (50) step();
    check_eq("clr_first_1k",  32'(first_1k),  32'd26);
    check_eq("clr_first_1hz", 32'(first_1hz), 32'd56);
    check_eq("clr_cnt_1k",    32'(cnt_1k),    32'd5);

    // Bouncing button, 7-clock segments, then settles high.
    clear_counts();
    for (int i = 0; i < 56; i++) begin
      i_btn = ((i / 7) % 2 == 0);
      step();
    end
`ifdef TICK_GEN_DEBOUNCE_EN
    check_eq("bounce_go_cnt", 32'(cnt_go), 32'd0);
`else
    check_eq("bounce_go_cnt", 32'(cnt_go), 32'd4);
`endif
    i_btn      = 1'b1;
    settle_cyc = n_edge;
    clear_counts();
    repeat (60) step();
    check_eq("settle_go_cnt", 32'(cnt_go), 32'd1);
    check_eq("settle_lvl",    32'(o_btn_lvl), 32'd1);
`ifdef TICK_GEN_DEBOUNCE_EN
    check_eq("settle_go_win",
             32'((first_go - settle_cyc >= (DB_MS - 1) * DIV) &&
                 (first_go - settle_cyc <= DB_MS * DIV + 3)), 32'd1);
`else
    check_eq("settle_go_delay", 32'(first_go - settle_cyc), 32'd3);
`endif

    // Long clean press and clean release.
    i_btn = 1'b0;
    repeat (60) step();
    i_btn = 1'b1;
    clear_counts();
    repeat (300) step();
    check_eq("hold_go_cnt", 32'(cnt_go), 32'd1);
    i_btn    = 1'b0;
    rel_cyc  = n_edge;
    lvl_fall = -1;
    clear_counts();
    for (int i = 0; i < 60; i++) begin
      step();
      if (o_btn_lvl === 1'b0 && lvl_fall < 0) lvl_fall = n_edge - rel_cyc;
    end
    check_eq("release_go_cnt", 32'(cnt_go), 32'd0);
`ifdef TICK_GEN_DEBOUNCE_EN
    check_eq("release_lvl_win",
             32'((lvl_fall >= (DB_MS - 1) * DIV) && (lvl_fall <= DB_MS * DIV + 3)), 32'd1);
`else
    check_eq("release_lvl_delay", 32'(lvl_fall), 32'd3);
`endif

    // Reset two ticks into a pending press, right while the fast strobe is high.
    i_btn = 1'b1;
    repeat (3) step();
    ticks_seen = 0;
    for (int i = 0; i < 4 * DIV && ticks_seen < 2; i++) begin
      step();
      if (exp_1k) ticks_seen++;
    end
    check_eq("wait_hi_ticks", 32'(ticks_seen), 32'd2);
    #1 i_rstn = 1'b0;
    #1;
    check_eq("async_rst_1k",  32'(o_pls_1k),  32'd0);
    check_eq("async_rst_1hz", 32'(o_pls_1hz), 32'd0);
    check_eq("async_rst_lvl", 32'(o_btn_lvl), 32'd0);
    check_eq("async_rst_go",  32'(o_go),      32'd0);
    step();
    i_rstn = 1'b1;
    clear_counts();
    repeat (40) step();
    check_eq("post_rst_go_cnt", 32'(cnt_go), 32'd1);
`ifdef TICK_GEN_DEBOUNCE_EN
    check_eq("post_rst_first_go", 32'(first_go), 32'(DB_MS * DIV));
`else
    check_eq("post_rst_first_go", 32'(first_go), 32'd3);
`endif

    // Random button segments and sporadic clears, one reset in the middle.
    seg_left = 0;
    for (int i = 0; i < 2400; i++) begin
      if (i == 1200) do_reset();
      if (seg_left == 0) begin
        i_btn    = 1'($urandom_range(0, 1));
        seg_left = $urandom_range(1, 45);
      end
      seg_left--;
      i_clr = ($urandom_range(0, 99) < 2);
      step();
    end
    i_clr = 1'b0;
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
